acc_sequencer: RTL
==================

# acc_sequencer

Instruction sequencer that sits directly upstream of the 16-bit accumulator register in the accumulator datapath. It fetches 16-bit instructions from program memory, decodes them, and drives the accumulator's operand (`Entrada`), write-enable (`WrAcc`) and clear (`Clear`) inputs, plus the data-memory address and write strobe. The accumulator adds `Entrada` when `WrAcc` is set. It gives `WrAcc` priority over `Clear` in the same cycle. This block therefore never asserts the two together and performs loads as a clear cycle followed by an add cycle.

## Interface
- `PC_W`, default 11: program counter / data address width.
- `clk` in 1: single clock; all state updates on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Instr` in 16: program-memory read data at address `PC`; asynchronous-read memory. [15:11] opcode, [10:0] operand.
- `PC` out PC_W: program counter, registered.
- `RamDato` in 16: data-memory read data at `RamAddr`; asynchronous-read memory.
- `RamAddr` out PC_W: data-memory address, equals IR[10:0].
- `WrRam` out 1: data-memory write strobe. The top level routes accumulator `Salida` to the RAM data input.
- `Entrada` out 16: operand to accumulator.
- `WrAcc` out 1: accumulator add-enable.
- `Clear` out 1: accumulator clear.
- `Halt` out 1: processor stopped.
- `Illegal` out 1: undefined opcode trapped; see Configuration.

## Operation
- Internal regs: `state`, `IR` (16), `PC`.
- Opcodes:
  - 00000 HLT
  - 00001 STO
  - 00010 LD
  - 00011 LDI
  - 00100 ADD
  - 00101 ADDI
  - 00110 SUB
  - 00111 SUBI
  - all others undefined.
- Operand value:
  - Memory forms use `RamDato`.
  - Immediate forms use IR[10:0] sign-extended to 16 bits, with IR[10] replicated.
  - SUB/SUBI drive the two's complement, ~x+1 mod 2^16, so −(−32768) = −32768.
  - Overflow is not detected; the accumulator wraps.
- States:
  - FETCH: IR <= `Instr`; PC <= PC+1 mod 2^PC_W, so 0x7FF wraps to 0x000. Next: DECODE.
  - DECODE:
    - HLT -> HALT.
    - STO -> STORE.
    - LD, LDI -> CLR.
    - ADD, ADDI, SUB, SUBI -> ACC.
    - Undefined -> FETCH (NOP).
  - CLR: `Clear`=1. Next: ACC.
  - ACC: `WrAcc`=1, `Entrada`=operand value. Next: FETCH.
  - STORE: `WrRam`=1. Next: FETCH.
  - HALT: `Halt`=1; terminal until reset. PC and IR are frozen.
- `Entrada` is 0 in every state except ACC.
- `WrAcc`, `Clear`, `WrRam` and `Halt` are decoded from `state` only and are mutually exclusive.
- `RamAddr` = IR[10:0] in all states.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - state=FETCH, PC=0, IR=0.
  - All outputs 0.
  - First fetch occurs on the first rising edge after `Reset_n` goes high.
- Cycles per instruction:
  - LD/LDI: 4 (FETCH, DECODE, CLR, ACC).
  - ADD/ADDI/SUB/SUBI: 3.
  - STO: 3.
  - NOP: 2.
  - HLT: `Halt` high from the 3rd cycle onward.
- Accumulator update lands on the rising edge that ends the ACC cycle.
- STO writes the value the accumulator holds at that time, including the result of the immediately preceding instruction.
- `Entrada` in ACC is combinational from `RamDato`; the memory must settle within one cycle of the `RamAddr` change at the DECODE edge.
- Reset mid-instruction aborts it; no partial `WrAcc`/`WrRam` pulse is issued after reset assertion.

## Configuration
- `ACC_SEQ_ILLEGAL_HALT_EN` defined: an undefined opcode in DECODE goes to HALT with `Illegal`=1 and `Halt`=1; both stay high until reset.
- Not defined: an undefined opcode is a 2-cycle NOP, and `Illegal` is tied to 0.

## Test plan
- Reset then LDI 5 (0x1805): CLR pulse in cycle 3, `WrAcc` with `Entrada`=0x0005 in cycle 4, and `Clear`/`WrAcc` never high together; PC=1 after cycle 1.
- SUBI 1 (0x3801) then ADDI −1 (0x2FFF): `Entrada`=0xFFFF in both ACC cycles; starting from accumulator 5, it reads 3 after the second ACC cycle.
- RAM[0x010]=0x8000, program LD 0x010 then SUB 0x010: `Entrada`=0x8000 in both ACC cycles; the accumulator ends at 0x0000 (wraps).
- STO 0x020 after LDI 7: `WrRam`=1 for exactly one cycle with `RamAddr`=0x020 while the accumulator holds 7; no `WrAcc` in that instruction.
- PC=0x7FF preset by program flow: fetch wraps PC to 0x000; opcode 0x1F executes as a NOP (macro off), or sets `Illegal`=1 and `Halt`=1 permanently (macro on).
- HLT reached, then `Reset_n` pulsed low mid-cycle: outputs clear immediately, `Halt` drops, and execution restarts from PC=0.

Source files
------------

// File: rtl/acc_sequencer_if.sv
// acc_sequencer_if: program memory, data memory and accumulator control bundle of the sequencer
interface acc_sequencer_if #(
  parameter int PC_W = 11
);
  logic [15:0]     Instr;
  logic [PC_W-1:0] PC;
  logic [15:0]     RamDato;
  logic [PC_W-1:0] RamAddr;
  logic            WrRam;
  logic [15:0]     Entrada;
  logic            WrAcc;
  logic            Clear;
  logic            Halt;
  logic            Illegal;
  modport master (
    input  Instr, RamDato,
    output PC, RamAddr, WrRam, Entrada, WrAcc, Clear, Halt, Illegal
  );
  modport slave (
    output Instr, RamDato,
    input  PC, RamAddr, WrRam, Entrada, WrAcc, Clear, Halt, Illegal
  );
endinterface

// File: rtl/acc_sequencer.sv
// acc_sequencer: fetch/decode sequencer driving the accumulator; ACC_SEQ_ILLEGAL_HALT_EN traps undefined opcodes
module acc_sequencer #(
  parameter int PC_W = 11
) (
  input  logic            clk,
  input  logic            Reset_n,
  acc_sequencer_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, CLR, ACC, STORE, HALT, TRAP} state_t;
  state_t          state_q, state_d, undef_nxt;
  logic [15:0]     ir_q, ir_d, imm, src;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [4:0]      op;
  assign op  = ir_q[15:11];
  assign imm = {{5{ir_q[10]}}, ir_q[10:0]};
  assign src = ir_q[11] ? imm : bus.RamDato;
`ifdef ACC_SEQ_ILLEGAL_HALT_EN
  assign undef_nxt   = TRAP;
  assign bus.Illegal = state_q == TRAP;
`else
  assign undef_nxt   = FETCH;
  assign bus.Illegal = 1'b0;
`endif
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    case (state_q)
      FETCH: begin
        ir_d    = bus.Instr;
        pc_d    = pc_q + PC_W'(1);
        state_d = DECODE;
      end
      DECODE:     state_d = op > 5'd7 ? undef_nxt : op == 5'd0 ? HALT : op == 5'd1 ? STORE : op[2] ? ACC : CLR;
      CLR:        state_d = ACC;
      ACC, STORE: state_d = FETCH;
      default:    state_d = state_q;
    endcase
  end
  assign bus.PC      = pc_q;
  assign bus.RamAddr = PC_W'(ir_q[10:0]);
  assign bus.WrAcc   = state_q == ACC;
  assign bus.Clear   = state_q == CLR;
  assign bus.WrRam   = state_q == STORE;
  assign bus.Halt    = state_q == HALT || state_q == TRAP;
  assign bus.Entrada = state_q != ACC ? 16'd0 : op[2:1] == 2'b11 ? ~src + 16'd1 : src;
endmodule
